// File: rtl/spi_mcp4822_dac_if.sv
// ---------------------------------------------------------------------------
// spi_mcp4822_dac_if
//
// Sample-side bus of the MCP4822 audio transmitter: one stereo pair of
// audio words presented on a single-cycle strobe, plus the transmitter's
// status flags going back to the source.
//
//   sample_left  [15:0]  channel A sample        (master -> slave)
//   sample_right [15:0]  channel B sample        (master -> slave)
//   sample_valid         one-cycle pair strobe   (master -> slave)
//   busy                 transfer in progress    (slave  -> master)
//   overrun              strobe dropped, 1 cycle (slave  -> master)
// ---------------------------------------------------------------------------
interface spi_mcp4822_dac_if;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  modport master (
    output sample_left,
    output sample_right,
    output sample_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    output busy,
    output overrun
  );
endinterface

// File: rtl/spi_mcp4822_dac.sv
// ---------------------------------------------------------------------------
// spi_mcp4822_dac
//
// Stereo audio transmitter for an MCP4822 dual 12-bit DAC. A stereo pair
// accepted on sif.sample_valid is sent as two 16-bit SPI mode 0,0 frames
// (left -> channel A, right -> channel B). An LDAC pulse then updates both
// DAC outputs together.
//
// Sequence: IDLE -> FRAME_A -> GAP_A -> FRAME_B -> GAP_B -> LDAC -> IDLE
//   FRAME_x : 16 bits, each bit = D cycles SCK low + D cycles SCK high
//   GAP_x   : D cycles with CS_n high
//   LDAC    : D cycles with LDAC_n low
// The whole transfer keeps busy high for 67*D cycles.
//
// Ports
//   clk          single clock
//   reset        asynchronous, active-high
//   sif          sample bus (slave side): samples, strobe, busy, overrun
//   dac_cs_n     chip select, active low
//   dac_sck      SPI clock, idles low
//   dac_mosi     serial data, MSB first, changes at the start of low phases
//   dac_ldac_n   output latch pulse, active low
//
// Parameters
//   CLK_DIV          clk cycles per SCK half-period (D), 1..255
//   AUDIO_BIT_WIDTH  sample width, fixed at 16
//   SIGNED_INPUT     1 = two's complement samples (MSB inverted to offset)
//   GAIN_X1          value driven on the GA_n bit (1 = 1x gain)
// ---------------------------------------------------------------------------
module spi_mcp4822_dac #(
  parameter int CLK_DIV         = 4,
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int SIGNED_INPUT    = 0,
  parameter int GAIN_X1         = 1
) (
  input  logic              clk,
  input  logic              reset,
  spi_mcp4822_dac_if.slave  sif,
  output logic              dac_cs_n,
  output logic              dac_sck,
  output logic              dac_mosi,
  output logic              dac_ldac_n
);

  localparam int         MSB       = AUDIO_BIT_WIDTH - 1;
  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [3:0] LAST_BIT  = 4'd15;
  localparam logic       GAIN_BIT  = (GAIN_X1 != 0);
  localparam logic       SIGN_FLIP = (SIGNED_INPUT != 0);

  typedef enum logic [2:0] {
    IDLE,
    FRAME_A,
    GAP_A,
    FRAME_B,
    GAP_B,
    LDAC
  } state_t;

  state_t      state,   state_d;
  logic [7:0]  div_cnt, div_cnt_d;   // clk cycles within the current half-period
  logic [3:0]  bit_cnt, bit_cnt_d;   // bit index within the frame, wraps 15 -> 0
  logic [15:0] shreg,   shreg_d;     // current frame, bit on the wire is [15]
  logic [15:0] frame_b, frame_b_d;   // channel B frame held until GAP_A ends
  logic        busy_q,  busy_d;
  logic        overrun_q, overrun_d;
  logic        cs_n_d, sck_d, mosi_d, ldac_n_d;
  logic        div_last;

  // Offset-binary view of the inputs: two's complement becomes offset
  // binary by flipping the sign bit.
  logic [15:0] left_ob, right_ob;
  logic [15:0] frame_a_new, frame_b_new;

  assign left_ob  = sif.sample_left  ^ {SIGN_FLIP, {MSB{1'b0}}};
  assign right_ob = sif.sample_right ^ {SIGN_FLIP, {MSB{1'b0}}};

  // Command nibble {channel, 0, GA_n, SHDN_n} then the top 12 sample bits.
  assign frame_a_new = {1'b0, 1'b0, GAIN_BIT, 1'b1, left_ob[MSB -: 12]};
  assign frame_b_new = {1'b1, 1'b0, GAIN_BIT, 1'b1, right_ob[MSB -: 12]};

  // The DAC resolves 12 bits; the low nibble of each sample is dropped.
  logic unused_low_bits;
  assign unused_low_bits = ^{left_ob[MSB-12:0], right_ob[MSB-12:0]};

  assign div_last = (div_cnt == DIV_LAST);

  assign sif.busy    = busy_q;
  assign sif.overrun = overrun_q;

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // through the block leaves it unassigned and infers a latch.
    state_d   = state;
    div_cnt_d = div_last ? 8'd0 : div_cnt + 8'd1;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    frame_b_d = frame_b;
    busy_d    = busy_q;
    cs_n_d    = dac_cs_n;
    sck_d     = dac_sck;
    mosi_d    = dac_mosi;
    ldac_n_d  = dac_ldac_n;
    // Any strobe outside IDLE is dropped, including the LDAC -> IDLE cycle.
    overrun_d = sif.sample_valid && (state != IDLE);

    unique case (state)
      IDLE: begin
        div_cnt_d = 8'd0;
        if (sif.sample_valid) begin
          state_d   = FRAME_A;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          sck_d     = 1'b0;
          mosi_d    = frame_a_new[15];
          shreg_d   = frame_a_new;
          frame_b_d = frame_b_new;
          bit_cnt_d = 4'd0;
        end
      end

      FRAME_A, FRAME_B: begin
        if (div_last) begin
          if (!dac_sck) begin
            sck_d = 1'b1;                 // rising edge: DAC samples MOSI
          end else begin
            sck_d     = 1'b0;             // falling edge: next low phase
            bit_cnt_d = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              // Last fall and CS_n release happen on the same edge.
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              state_d = (state == FRAME_A) ? GAP_A : GAP_B;
            end else begin
              shreg_d = {shreg[14:0], 1'b0};
              mosi_d  = shreg[14];
            end
          end
        end
      end

      GAP_A: begin
        if (div_last) begin
          state_d   = FRAME_B;
          cs_n_d    = 1'b0;
          sck_d     = 1'b0;
          shreg_d   = frame_b;
          mosi_d    = frame_b[15];
          bit_cnt_d = 4'd0;
        end
      end

      GAP_B: begin
        if (div_last) begin
          state_d  = LDAC;
          ldac_n_d = 1'b0;
        end
      end

      LDAC: begin
        if (div_last) begin
          state_d  = IDLE;
          ldac_n_d = 1'b1;
          busy_d   = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        cs_n_d   = 1'b1;
        sck_d    = 1'b0;
        mosi_d   = 1'b0;
        ldac_n_d = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register updates from the
    // values present before the edge, independent of statement order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers; reset also discards the latched pair.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= 8'd0;
      bit_cnt    <= 4'd0;
      shreg      <= 16'd0;
      frame_b    <= 16'd0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_sck    <= 1'b0;
      dac_mosi   <= 1'b0;
      dac_ldac_n <= 1'b1;
    end else begin
      div_cnt    <= div_cnt_d;
      bit_cnt    <= bit_cnt_d;
      shreg      <= shreg_d;
      frame_b    <= frame_b_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      dac_cs_n   <= cs_n_d;
      dac_sck    <= sck_d;
      dac_mosi   <= mosi_d;
      dac_ldac_n <= ldac_n_d;
    end
  end

endmodule

// File: tb/tb_spi_mcp4822_dac.sv
// ---------------------------------------------------------------------------
// tb_spi_mcp4822_dac
//
// Four transmitter instances with different parameter sets:
//   unit 0: D=2, unsigned, 1x gain   (main, overrun, reset cases)
//   unit 1: D=2, signed,   1x gain
//   unit 2: D=2, unsigned, 2x gain
//   unit 3: D=1, unsigned, 1x gain   (back-to-back at minimum divider)
// Stimulus pushes hand-computed frame words into a queue; an SPI monitor
// captures frames on the DAC pins and compares them as they complete.
// ---------------------------------------------------------------------------
module tb_spi_mcp4822_dac;

  localparam int N = 4;

  function automatic int div_of(input int u);
    return (u == 3) ? 1 : 2;
  endfunction
  function automatic int signed_of(input int u);
    return (u == 1) ? 1 : 0;
  endfunction
  function automatic int gain_of(input int u);
    return (u == 2) ? 0 : 1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst;
  logic [N-1:0] valid;
  logic [15:0]  left_s  [N];
  logic [15:0]  right_s [N];
  wire  [N-1:0] busy_w, ovr_w, cs_w, sck_w, mosi_w, ldac_w;

  generate
    for (genvar i = 0; i < N; i++) begin : g_unit
      spi_mcp4822_dac_if sif ();
      assign sif.sample_left  = left_s[i];
      assign sif.sample_right = right_s[i];
      assign sif.sample_valid = valid[i];
      assign busy_w[i]        = sif.busy;
      assign ovr_w[i]         = sif.overrun;

      spi_mcp4822_dac #(
        .CLK_DIV        (div_of(i)),
        .AUDIO_BIT_WIDTH(16),
        .SIGNED_INPUT   (signed_of(i)),
        .GAIN_X1        (gain_of(i))
      ) u_dut (
        .clk       (clk),
        .reset     (rst[i]),
        .sif       (sif),
        .dac_cs_n  (cs_w[i]),
        .dac_sck   (sck_w[i]),
        .dac_mosi  (mosi_w[i]),
        .dac_ldac_n(ldac_w[i])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          unit;
    logic [15:0] frame;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input int u, input logic [15:0] f);
    exp_t e;
    e.unit  = u;
    e.frame = f;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------
  // SPI / status monitor, sampled on the falling clk edge
  // ---------------------------------------------------------------------
  logic        prev_sck  [N] = '{default: 1'b0};
  logic        prev_cs   [N] = '{default: 1'b1};
  logic        prev_busy [N] = '{default: 1'b0};
  logic        prev_ldac [N] = '{default: 1'b1};
  logic        aborted   [N] = '{default: 1'b0};
  logic        overlap   [N] = '{default: 1'b0};
  logic [15:0] shift     [N] = '{default: 16'h0};
  int          rises     [N] = '{default: 0};
  int          cs_low    [N] = '{default: 0};
  int          busy_cnt  [N] = '{default: 0};
  int          ldac_cnt  [N] = '{default: 0};
  int          ldac_pulses [N] = '{default: 0};
  int          ovr_pulses  [N] = '{default: 0};

  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < N; u++) begin
      if (rst[u]) aborted[u] = 1'b1;
      if (ovr_w[u]) ovr_pulses[u]++;

      // Start of a transfer or frame clears the capture state.
      if (busy_w[u] && !prev_busy[u]) begin
        busy_cnt[u] = 0;
        aborted[u]  = 1'b0;
      end
      if (!cs_w[u] && prev_cs[u]) begin
        rises[u]   = 0;
        cs_low[u]  = 0;
        shift[u]   = 16'h0;
        aborted[u] = 1'b0;
      end

      if (sck_w[u] && !prev_sck[u]) begin
        shift[u] = {shift[u][14:0], mosi_w[u]};
        rises[u]++;
      end
      if (!cs_w[u]) cs_low[u]++;
      if (busy_w[u]) busy_cnt[u]++;

      // Frame complete: compare against the scoreboard.
      if (cs_w[u] && !prev_cs[u] && !aborted[u]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u%0d frame: got %h, required no frame", u, shift[u]);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("u%0d frame unit", u), u, e.unit);
          check($sformatf("u%0d frame word", u), shift[u], e.frame);
          check($sformatf("u%0d sck rises per frame", u), rises[u], 16);
          check($sformatf("u%0d cs_n low cycles", u), cs_low[u], 32 * div_of(u));
        end
      end

      if (!busy_w[u] && prev_busy[u] && !aborted[u])
        check($sformatf("u%0d busy cycles", u), busy_cnt[u], 67 * div_of(u));

      if (!ldac_w[u]) begin
        ldac_cnt[u]++;
        if (!cs_w[u]) overlap[u] = 1'b1;
      end
      if (ldac_w[u] && !prev_ldac[u]) begin
        ldac_pulses[u]++;
        check($sformatf("u%0d ldac low cycles", u), ldac_cnt[u], div_of(u));
        check($sformatf("u%0d ldac while cs low", u), overlap[u], 0);
        ldac_cnt[u] = 0;
        overlap[u]  = 1'b0;
      end

      prev_sck[u]  = sck_w[u];
      prev_cs[u]   = cs_w[u];
      prev_busy[u] = busy_w[u];
      prev_ldac[u] = ldac_w[u];
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge)
  // ---------------------------------------------------------------------
  task automatic strobe(input int u, input logic [15:0] l, input logic [15:0] r);
    left_s[u]  = l;
    right_s[u] = r;
    valid[u]   = 1'b1;
    @(negedge clk);
    valid[u]   = 1'b0;
  endtask

  task automatic wait_idle(input int u);
    int n = 0;
    while (busy_w[u] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d returned idle within budget", u), busy_w[u], 0);
  endtask

  task automatic first_rise(input int u, input int d);
    int n = 0;
    while (!sck_w[u] && n < 600) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("u%0d cs-to-first-rise cycles", u), n, d);
  endtask

  function automatic logic [5:0] pins(input int u);
    return {busy_w[u], ovr_w[u], cs_w[u], sck_w[u], mosi_w[u], ldac_w[u]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    int l0, o0;
    rst   = '1;
    valid = '0;
    for (int u = 0; u < N; u++) begin
      left_s[u]  = 16'h0;
      right_s[u] = 16'h0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < N; u++)
      check($sformatf("u%0d pins in reset", u), pins(u), 6'b001001);
    rst = '0;
    @(negedge clk);
    check("u0 pins idle after release", pins(0), 6'b001001);

    // Main case: frames, timing, LDAC, busy length.
    push_exp(0, 16'h3ABC);
    push_exp(0, 16'hB123);
    l0 = ldac_pulses[0];
    strobe(0, 16'hABC0, 16'h1230);
    check("u0 first cycle busy/cs_n/sck/mosi",
          {busy_w[0], cs_w[0], sck_w[0], mosi_w[0]}, 4'b1000);
    first_rise(0, 2);
    wait_idle(0);
    repeat (2) @(negedge clk);
    check("u0 ldac pulses per transfer", ldac_pulses[0] - l0, 1);

    // Signed input on unit 1.
    push_exp(1, 16'h3800);
    push_exp(1, 16'hB7FF);
    strobe(1, 16'h0000, 16'hFFF0);
    wait_idle(1);

    // 2x gain and low-nibble truncation on unit 2.
    push_exp(2, 16'h1FFF);
    push_exp(2, 16'h9000);
    strobe(2, 16'hFFFF, 16'h0005);
    wait_idle(2);

    // Overrun ten cycles after an accepted strobe.
    o0 = ovr_pulses[0];
    push_exp(0, 16'h3555);
    push_exp(0, 16'hBAAA);
    strobe(0, 16'h5550, 16'hAAA0);
    repeat (9) @(negedge clk);
    strobe(0, 16'hFFF0, 16'hFFF0);
    check("u0 overrun pulse after busy strobe", ovr_w[0], 1);
    @(negedge clk);
    check("u0 overrun single cycle", ovr_w[0], 0);
    wait_idle(0);

    // Strobe on the LDAC -> IDLE edge is dropped; the next cycle is accepted.
    push_exp(0, 16'h3111);
    push_exp(0, 16'hB222);
    push_exp(0, 16'h3444);
    push_exp(0, 16'hB555);
    strobe(0, 16'h1110, 16'h2220);
    repeat (133) @(negedge clk);
    check("u0 last busy cycle in ldac", {busy_w[0], ldac_w[0]}, 2'b10);
    strobe(0, 16'h7770, 16'h8880);
    check("u0 strobe at ldac exit dropped", {ovr_w[0], busy_w[0]}, 2'b10);
    strobe(0, 16'h4440, 16'h5550);
    check("u0 strobe in first idle cycle taken", busy_w[0], 1);
    wait_idle(0);
    repeat (2) @(negedge clk);
    check("u0 overrun pulse count", ovr_pulses[0] - o0, 2);

    // Asynchronous reset in the middle of frame B.
    push_exp(0, 16'h3135);
    l0 = ldac_pulses[0];
    strobe(0, 16'h1350, 16'h2460);
    repeat (97) @(negedge clk);
    #2 rst[0] = 1'b1;
    #1 check("u0 pins right after async reset", pins(0), 6'b001001);
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (100) @(negedge clk);
    check("u0 no ldac after aborted transfer", ldac_pulses[0] - l0, 0);
    push_exp(0, 16'h3DEF);
    push_exp(0, 16'hB456);
    strobe(0, 16'hDEF0, 16'h4560);
    wait_idle(0);

    // Minimum divider, back-to-back transfers on unit 3.
    push_exp(3, 16'h3ABC);
    push_exp(3, 16'hB123);
    push_exp(3, 16'h3FED);
    push_exp(3, 16'hB001);
    strobe(3, 16'hABC0, 16'h1230);
    first_rise(3, 1);
    wait_idle(3);
    strobe(3, 16'hFED0, 16'h0010);
    check("u3 back-to-back strobe taken", busy_w[3], 1);
    wait_idle(3);
    repeat (4) @(negedge clk);
    check("u3 no overrun", ovr_pulses[3], 0);

    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_mcp4822_dac.md
# spi_mcp4822_dac

Audio output transmitter: the DAC counterpart of the ADC sampling path. Accepts a stereo pair of 16-bit audio sample words on a single-cycle strobe and shifts them out over SPI mode 0,0 to an MCP4822 dual 12-bit DAC. Left goes to channel A and right to channel B. The two outputs are then updated together with an LDAC pulse. Sits between the audio mixer's sample words and the board's DAC pins, in the `clk` domain.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCK half-period (D); legal range 1..255.
- `AUDIO_BIT_WIDTH`, 16: input sample width; fixed at 16 for this block.
- `SIGNED_INPUT`, 0: 0 = samples are unsigned offset-binary; 1 = two's complement, so sample bit 15 is inverted before transmission.
- `GAIN_X1`, 1: value driven on the GA_n bit (1 = 1x gain, 0 = 2x gain).
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high reset.
- `sample_left` in 16: channel A sample.
- `sample_right` in 16: channel B sample.
- `sample_valid` in 1: one-cycle strobe; both samples are valid in that cycle.
- `busy` out 1: high while a transfer is in progress.
- `overrun` out 1: one-cycle pulse when `sample_valid` arrives while `busy`.
- `dac_cs_n` out 1: chip select, active low.
- `dac_sck` out 1: SPI clock, idles low.
- `dac_mosi` out 1: serial data, MSB first.
- `dac_ldac_n` out 1: latch pulse, active low.

## Operation
- Reset values: `busy`=0, `overrun`=0, `dac_cs_n`=1, `dac_sck`=0, `dac_mosi`=0, `dac_ldac_n`=1. All are registered outputs.
- Frame word is 16 bits, MSB first:
  - bit15 = channel select (0 = A, 1 = B)
  - bit14 = 0
  - bit13 = `GAIN_X1`
  - bit12 = 1 (SHDN_n, output active)
  - bits11:0 = s[15:4], where s is the sample with bit 15 inverted when `SIGNED_INPUT`=1. The low 4 bits are discarded.
- States: IDLE → FRAME_A → GAP_A → FRAME_B → GAP_B → LDAC → IDLE.
- IDLE:
  - `sample_valid`=1 latches both samples and moves to FRAME_A.
  - Inputs are not sampled again until the next return to IDLE.
- FRAME_x:
  - `dac_cs_n`=0 for the whole state.
  - 16 bits; each bit is an SCK-low phase of D cycles followed by an SCK-high phase of D cycles.
  - `dac_mosi` changes only at the start of a low phase. The DAC samples on the rising edge.
  - A half-period counter and a 4-bit bit counter control the shifting. The bit counter wraps from 15 to leave the state.
- GAP_x: `dac_cs_n`=1, `dac_sck`=0 for D cycles.
- LDAC: `dac_ldac_n`=0 for D cycles, then IDLE.
- `sample_valid` while `busy`:
  - The sample is dropped and `overrun` pulses the next cycle.
  - The transfer in progress is unaffected.
- `sample_valid` in the same cycle that LDAC→IDLE occurs: dropped with `overrun`. A sample is accepted only when the block was already in IDLE in that cycle.
- Reset asserted mid-transfer:
  - All outputs go to their reset values immediately (asynchronous), with no partial-frame completion.
  - The latched samples are discarded.

## Timing
- `sample_valid` high at edge k:
  - `busy`=1, `dac_cs_n`=0, `dac_mosi`=frame A bit15 and `dac_sck`=0, all from edge k+1.
  - First SCK rising edge at edge k+1+D.
- The CS_n-low-to-first-rise setup time is D cycles. The last SCK fall coincides with `dac_cs_n` rising (edge at end of frame).
- Each frame keeps `dac_cs_n` low for 32·D cycles.
- Total `busy` duration = 32D + D + 32D + D + D = 67·D cycles (268 at D=4).
- `dac_ldac_n` low only while `dac_cs_n`=1, starting D cycles after frame B ends.
- Back-to-back: the next accepted `sample_valid` is the first cycle with `busy`=0, giving a minimum sample period of 67·D+1 cycles.
- At 27 MHz, D=4 gives a 3.375 MHz SCK and supports up to about 100 kHz stereo sample rate.

## Test plan
- CLK_DIV=2, SIGNED_INPUT=0, GAIN_X1=1; strobe left=16'hABC0, right=16'h1230. Required:
  - the SPI monitor captures frame A 16'h3ABC, then frame B 16'hB123;
  - exactly 16 rising edges per CS_n-low window;
  - one LDAC low pulse of 2 cycles;
  - `busy` high for exactly 134 cycles.
- SIGNED_INPUT=1; left=16'h0000, right=16'hFFF0 → frames 16'h3800 and 16'hB7FF.
- GAIN_X1=0, left=16'hFFFF → frame A 16'h1FFF; low nibble truncated.
- Strobe at t0, then strobe again at t0+10 → `overrun` pulses once; frames carry only the first pair; a strobe in the first cycle with `busy`=0 is accepted.
- Assert `reset` asynchronously mid-way through frame B (between clock edges) → `dac_cs_n`=1, `dac_sck`=0, `busy`=0 before the next edge; no LDAC pulse; the next strobe after release transmits cleanly.
- CLK_DIV=1, two back-to-back accepted strobes → each SCK phase is 1 cycle; both transfers are correct with no lost bits.
